fetch_branch_ctrl: RTL and testbench

//  Consumer side of the PC interface: reads PC counter, fetches the instruction at that

---
 rtl/fetch_branch_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_fetch_branch_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_branch_ctrl.sv
// fetch_branch_ctrl: fetches the instruction at the current PC from ROM (req/ack),
// decodes branch opcodes and drives branch/add plus a one-cycle pc_adv strobe to the PC.
// Halts on the HALT opcode or when the ROM fails to answer within TIMEOUT wait cycles.
// Optional feature macro: BRANCH_STATS_EN (adds taken_cnt / instr_cnt saturating counters).
module fetch_branch_ctrl #(
    parameter int unsigned IW      = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          start,
    input  logic [7:0]    pc,
    output logic [7:0]    rom_addr,
    output logic          rom_req,
    input  logic          rom_ack,
    input  logic [IW-1:0] rom_data,
    input  logic          zero_flag,
    output logic          branch,
    output logic [7:0]    add,
    output logic          pc_adv,
    output logic [IW-1:0] ir,
    output logic          halted,
`ifdef BRANCH_STATS_EN
    output logic [7:0]    taken_cnt,
    output logic [7:0]    instr_cnt,
`endif
    output logic          fetch_err
);

    localparam int unsigned AW    = 8;
    localparam int unsigned TMO_W = 8;

    localparam logic [3:0] OP_BR   = 4'hB;
    localparam logic [3:0] OP_BZ   = 4'hC;
    localparam logic [3:0] OP_BNZ  = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DECODE,
        S_ADVANCE,
        S_HALT
    } state_t;

    state_t           state, state_n;
    logic [AW-1:0]    rom_addr_n;
    logic             rom_req_n;
    logic             branch_n;
    logic [AW-1:0]    add_n;
    logic             pc_adv_n;
    logic [IW-1:0]    ir_n;
    logic             halted_n;
    logic             fetch_err_n;
    logic [TMO_W-1:0] tmo, tmo_n, tmo_inc;
    logic [3:0]       op;

    assign op      = ir[15:12];
    assign tmo_inc = tmo + TMO_W'(1);

    // Next-state and next-output computation
    always_comb begin
        state_n     = state;
        rom_addr_n  = rom_addr;
        rom_req_n   = rom_req;
        branch_n    = branch;
        add_n       = add;
        pc_adv_n    = pc_adv;
        ir_n        = ir;
        halted_n    = halted;
        fetch_err_n = fetch_err;
        tmo_n       = tmo;
        case (state)
            S_IDLE: begin
                if (start) state_n = S_FETCH;
            end
            S_FETCH: begin
                rom_addr_n = pc;
                rom_req_n  = 1'b1;
                tmo_n      = '0;
                state_n    = S_WAIT;
            end
            S_WAIT: begin
                // an ack arriving on the final allowed cycle still wins over the timeout
                if (rom_ack) begin
                    ir_n      = rom_data;
                    rom_req_n = 1'b0;
                    state_n   = S_DECODE;
                end else begin
                    tmo_n = tmo_inc;
                    if (tmo_inc == TMO_W'(TIMEOUT)) begin
                        rom_req_n   = 1'b0;
                        fetch_err_n = 1'b1;
                        halted_n    = 1'b1;
                        state_n     = S_HALT;
                    end
                end
            end
            S_DECODE: begin
                case (op)
                    OP_BR: begin
                        branch_n = 1'b1;
                        add_n    = ir[7:0];
                    end
                    OP_BZ: begin
                        branch_n = zero_flag;
                        add_n    = zero_flag ? ir[7:0] : '0;
                    end
                    OP_BNZ: begin
                        branch_n = ~zero_flag;
                        add_n    = zero_flag ? '0 : ir[7:0];
                    end
                    default: begin
                        branch_n = 1'b0;
                        add_n    = '0;
                    end
                endcase
                if (op == OP_HALT) begin
                    halted_n = 1'b1;
                    state_n  = S_HALT;
                end else begin
                    pc_adv_n = 1'b1;
                    state_n  = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                branch_n = 1'b0;
                add_n    = '0;
                pc_adv_n = 1'b0;
                state_n  = S_FETCH;
            end
            S_HALT: begin
                halted_n  = 1'b1;
                rom_req_n = 1'b0;
                branch_n  = 1'b0;
                add_n     = '0;
                pc_adv_n  = 1'b0;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= S_IDLE;
            rom_addr  <= '0;
            rom_req   <= 1'b0;
            branch    <= 1'b0;
            add       <= '0;
            pc_adv    <= 1'b0;
            ir        <= '0;
            halted    <= 1'b0;
            fetch_err <= 1'b0;
            tmo       <= '0;
        end else begin
            state     <= state_n;
            rom_addr  <= rom_addr_n;
            rom_req   <= rom_req_n;
            branch    <= branch_n;
            add       <= add_n;
            pc_adv    <= pc_adv_n;
            ir        <= ir_n;
            halted    <= halted_n;
            fetch_err <= fetch_err_n;
            tmo       <= tmo_n;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [7:0] taken_cnt_n, instr_cnt_n;

    // Saturating counts of issued advances and taken branches
    always_comb begin
        taken_cnt_n = taken_cnt;
        instr_cnt_n = instr_cnt;
        if (pc_adv) begin
            if (instr_cnt != 8'hFF) instr_cnt_n = instr_cnt + 8'd1;
            if (branch && (taken_cnt != 8'hFF)) taken_cnt_n = taken_cnt + 8'd1;
        end
    end

    // Statistics registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            taken_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            taken_cnt <= taken_cnt_n;
            instr_cnt <= instr_cnt_n;
        end
    end
`else
    // statistics counters not built
`endif

endmodule

// File: tb/tb_fetch_branch_ctrl.sv
// Testbench for fetch_branch_ctrl: PC and ROM models, expected advances queued by the
// stimulus process and checked by an independent monitor on every pc_adv.
module tb_fetch_branch_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [7:0]  pc;
    logic [7:0]  rom_addr;
    logic        rom_req;
    logic        rom_ack;
    logic [15:0] rom_data;
    logic        zero_flag;
    logic        branch;
    logic [7:0]  add;
    logic        pc_adv;
    logic [15:0] ir;
    logic        halted;
    logic        fetch_err;
`ifdef BRANCH_STATS_EN
    logic [7:0]  taken_cnt;
    logic [7:0]  instr_cnt;
`endif

    fetch_branch_ctrl #(.IW(16), .TIMEOUT(15)) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .pc        (pc),
        .rom_addr  (rom_addr),
        .rom_req   (rom_req),
        .rom_ack   (rom_ack),
        .rom_data  (rom_data),
        .zero_flag (zero_flag),
        .branch    (branch),
        .add       (add),
        .pc_adv    (pc_adv),
        .ir        (ir),
        .halted    (halted),
`ifdef BRANCH_STATS_EN
        .taken_cnt (taken_cnt),
        .instr_cnt (instr_cnt),
`endif
        .fetch_err (fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] addr;
        logic       br;
        logic [7:0] add;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  pc_init  = 8'h00;
    logic [15:0] rom_mem [256];
    logic [7:0]  lat_mem [256];
    logic        zf_mem  [256];
    logic [7:0]  wait_cnt;
    logic        prev_adv;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // PC model: pc + add + 1 on each advance strobe
    always @(posedge clk or posedge clr) begin
        if (clr) pc <= pc_init;
        else if (pc_adv) pc <= pc + add + 8'd1;
    end

    // ROM model: ack after lat_mem[addr] request cycles, 0 means never
    always @(posedge clk or posedge clr) begin
        if (clr) wait_cnt <= 8'd0;
        else wait_cnt <= rom_req ? wait_cnt + 8'd1 : 8'd0;
    end

    always_comb begin
        rom_ack   = rom_req && (lat_mem[rom_addr] != 8'd0)
                    && (wait_cnt == 8'(lat_mem[rom_addr] - 8'd1));
        rom_data  = rom_ack ? rom_mem[rom_addr] : 16'hDEAD;
        zero_flag = zf_mem[rom_addr];
    end

    // Monitor: every advance must match the next queued expectation
    always @(negedge clk) begin
        if (!clr && pc_adv) begin
            check("pc_adv_width", 32'(prev_adv), 32'd0);
            if (sb.size() == 0) begin
                fail_now("unexpected_pc_adv");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("adv_addr", 32'(rom_addr), 32'(e.addr));
                check("adv_branch", 32'(branch), 32'(e.br));
                check("adv_add", 32'(add), 32'(e.add));
            end
        end
        prev_adv <= clr ? 1'b0 : pc_adv;
    end

    task automatic do_reset(input logic [7:0] p);
        pc_init = p;
        start   = 1'b0;
        clr     = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic run_to_halt(input int budget);
        int cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!halted && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        if (!halted) fail_now("halt_timeout");
    endtask

    initial begin
        int req_cycles;
        for (int i = 0; i < 256; i++) begin
            rom_mem[i] = 16'hF000;
            lat_mem[i] = 8'd1;
            zf_mem[i]  = 1'b0;
        end
        clr      = 1'b1;
        start    = 1'b0;
        prev_adv = 1'b0;
        repeat (2) @(negedge clk);
        // reset values while clr held
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_rom_req", 32'(rom_req), 32'd0);
        check("rst_branch", 32'(branch), 32'd0);
        check("rst_add", 32'(add), 32'd0);
        check("rst_pc_adv", 32'(pc_adv), 32'd0);
        check("rst_ir", 32'(ir), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_fetch_err", 32'(fetch_err), 32'd0);

        // branch program starting at 0x10
        rom_mem[8'h10] = 16'h1234;
        rom_mem[8'h11] = 16'hC003; lat_mem[8'h11] = 8'd3;
        rom_mem[8'h12] = 16'hC003; zf_mem[8'h12] = 1'b1; lat_mem[8'h12] = 8'd15;
        rom_mem[8'h16] = 16'hD005; zf_mem[8'h16] = 1'b1;
        rom_mem[8'h17] = 16'hD002;
        rom_mem[8'h1A] = 16'hB0EA;
        rom_mem[8'h05] = 16'hB0FE;
        rom_mem[8'h04] = 16'hF000;
        sb.push_back('{addr: 8'h10, br: 1'b0, add: 8'h00});
        sb.push_back('{addr: 8'h11, br: 1'b0, add: 8'h00});
        sb.push_back('{addr: 8'h12, br: 1'b1, add: 8'h03});
        sb.push_back('{addr: 8'h16, br: 1'b0, add: 8'h00});
        sb.push_back('{addr: 8'h17, br: 1'b1, add: 8'h02});
        sb.push_back('{addr: 8'h1A, br: 1'b1, add: 8'hEA});
        sb.push_back('{addr: 8'h05, br: 1'b1, add: 8'hFE});
        do_reset(8'h10);
        run_to_halt(300);
        check("p1_halted", 32'(halted), 32'd1);
        check("p1_fetch_err", 32'(fetch_err), 32'd0);
        check("p1_pc", 32'(pc), 32'h04);
        check("p1_rom_addr", 32'(rom_addr), 32'h04);
        check("p1_ir", 32'(ir), 32'hF000);
        check("p1_rom_req", 32'(rom_req), 32'd0);
        check("p1_sb_left", 32'(sb.size()), 32'd0);
`ifdef BRANCH_STATS_EN
        check("p1_instr_cnt", 32'(instr_cnt), 32'd7);
        check("p1_taken_cnt", 32'(taken_cnt), 32'd4);
`endif
        // start toggling while halted has no effect
        for (int i = 0; i < 6; i++) begin
            start = ~start;
            @(negedge clk);
        end
        start = 1'b0;
        check("p1_still_halted", 32'(halted), 32'd1);
        check("p1_pc_frozen", 32'(pc), 32'h04);

        // PC wrap 0xFF -> 0x00
        rom_mem[8'hFE] = 16'h0000;
        rom_mem[8'hFF] = 16'h7000;
        sb.push_back('{addr: 8'hFE, br: 1'b0, add: 8'h00});
        sb.push_back('{addr: 8'hFF, br: 1'b0, add: 8'h00});
        do_reset(8'hFE);
        check("p2_halt_cleared", 32'(halted), 32'd0);
        run_to_halt(100);
        check("p2_pc_wrap", 32'(pc), 32'h00);
        check("p2_fetch_err", 32'(fetch_err), 32'd0);
        check("p2_sb_left", 32'(sb.size()), 32'd0);

        // ROM never answers: timeout after 15 wait cycles
        lat_mem[8'h40] = 8'd0;
        do_reset(8'h40);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        req_cycles = 0;
        for (int i = 0; i < 100 && !halted; i++) begin
            @(negedge clk);
            if (rom_req) req_cycles++;
        end
        check("tmo_req_cycles", 32'(req_cycles), 32'd15);
        check("tmo_fetch_err", 32'(fetch_err), 32'd1);
        check("tmo_halted", 32'(halted), 32'd1);
        check("tmo_rom_req", 32'(rom_req), 32'd0);
        check("tmo_rom_addr", 32'(rom_addr), 32'h40);
        do_reset(8'h40);
        check("tmo_err_cleared", 32'(fetch_err), 32'd0);

        // clr pulse mid-WAIT drops the request without waiting for a clock edge
        start = 1'b1;
        repeat (5) @(negedge clk);
        start = 1'b0;
        check("mid_wait_req", 32'(rom_req), 32'd1);
        #2 clr = 1'b1;
        #1;
        check("clr_rom_req", 32'(rom_req), 32'd0);
        check("clr_rom_addr", 32'(rom_addr), 32'd0);
        check("clr_halted", 32'(halted), 32'd0);
        @(negedge clk);
        clr = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_rom_req", 32'(rom_req), 32'd0);
        check("idle_halted", 32'(halted), 32'd0);
        check("final_sb_left", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
